morse_rx_decoder: RTL



---
 rtl/morse_rx_if.sv | 13 +
 rtl/morse_rx_decoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/morse_rx_if.sv
// Decoded-letter output bundle of the Morse receiver: decoder drives it as master,
// display/LED logic consumes it as slave.
interface morse_rx_if;
    logic       letter_valid;
    logic [4:0] letter_code;
    logic [3:0] sym_bits;
    logic [2:0] sym_len;
    logic       sym_err;
    logic       word_space;

    modport master (output letter_valid, letter_code, sym_bits, sym_len, sym_err, word_space);
    modport slave  (input  letter_valid, letter_code, sym_bits, sym_len, sym_err, word_space);
endinterface

// File: rtl/morse_rx_decoder.sv
// Morse receiver: synchronizes a keyed line, times marks/spaces in units, decodes A-Z.
// Optional input debounce enabled with `define MORSE_RX_DEBOUNCE_EN.
module morse_rx_decoder #(
    parameter int UNIT_CYCLES = 25000000,
    parameter int CNT_W       = 25,
    parameter int DEB_CYCLES  = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_in,
    morse_rx_if.master rx
);
    typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE} state_t;

    if (UNIT_CYCLES < 2 || DEB_CYCLES < 1 || (UNIT_CYCLES - 1) >= (2 ** CNT_W)) begin : g_param_chk
        $error("morse_rx_decoder: bad UNIT_CYCLES/CNT_W/DEB_CYCLES");
    end

    logic       k_meta, k_sync, key_live, key_raw, key_s, key_d;
    logic [1:0] vld_pipe;

    // The line reads as low until it has been seen low once after reset, so a key
    // still held across reset release produces neither a rise nor a stray symbol.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            k_meta   <= 1'b0;
            k_sync   <= 1'b0;
            vld_pipe <= '0;
            key_live <= 1'b0;
        end else begin
            k_meta   <= key_in;
            k_sync   <= k_meta;
            vld_pipe <= {vld_pipe[0], 1'b1};
            if (vld_pipe[1] && !k_sync) key_live <= 1'b1;
        end
    end
    assign key_raw = k_sync & key_live;

`ifdef MORSE_RX_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);
    logic [DW-1:0] deb_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_s   <= 1'b0;
            deb_cnt <= '0;
        end else if (key_raw == key_s) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
            key_s   <= key_raw;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end
`else
    assign key_s = key_raw;
`endif

    logic rise, fall, edge_s, tick;
    logic [CNT_W-1:0] p;
    logic [2:0] u;

    assign rise   = key_s & ~key_d;
    assign fall   = ~key_s & key_d;
    assign edge_s = rise | fall;
    assign tick   = (p == CNT_W'(UNIT_CYCLES - 1));

    function automatic logic [4:0] lookup(input logic [2:0] len, input logic [3:0] bits);
        logic [4:0] c;
        c = 5'd31;
        case (len)
            3'd1: c = bits[0] ? 5'd19 : 5'd4;
            3'd2: case (bits[1:0])
                2'b00: c = 5'd8;  2'b01: c = 5'd0;  2'b10: c = 5'd13; default: c = 5'd12;
            endcase
            3'd3: case (bits[2:0])
                3'b000: c = 5'd18; 3'b001: c = 5'd20; 3'b010: c = 5'd17; 3'b011: c = 5'd22;
                3'b100: c = 5'd3;  3'b101: c = 5'd10; 3'b110: c = 5'd6;  default: c = 5'd14;
            endcase
            3'd4: case (bits)
                4'b0000: c = 5'd7;  4'b0001: c = 5'd21; 4'b0010: c = 5'd5;  4'b0100: c = 5'd11;
                4'b0110: c = 5'd15; 4'b0111: c = 5'd9;  4'b1000: c = 5'd1;  4'b1001: c = 5'd23;
                4'b1010: c = 5'd2;  4'b1011: c = 5'd24; 4'b1100: c = 5'd25; 4'b1101: c = 5'd16;
                default: c = 5'd31;
            endcase
            default: c = 5'd31;
        endcase
        return c;
    endfunction

    state_t     state, state_n;
    logic [3:0] acc_bits, acc_bits_n;
    logic [2:0] acc_len, acc_len_n;
    logic       ovf, ovf_n, armed, armed_n, lv_n, ws_n, complete;
    logic [4:0] code_n;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        acc_bits_n = acc_bits;
        acc_len_n  = acc_len;
        ovf_n      = ovf;
        armed_n    = armed;
        lv_n       = 1'b0;
        ws_n       = 1'b0;
        complete   = 1'b0;
        case (state)
            S_IDLE: begin
                if (rise) begin
                    state_n = S_MARK;
                end else if (armed && tick && u == 3'd6) begin
                    ws_n    = 1'b1;
                    armed_n = 1'b0;
                end
            end
            S_MARK: begin
                if (fall) begin
                    if (acc_len < 3'd4) begin
                        acc_bits_n = {acc_bits[2:0], (u >= 3'd2)};
                        acc_len_n  = acc_len + 3'd1;
                    end else begin
                        ovf_n = 1'b1;
                    end
                    state_n = S_SPACE;
                end
            end
            S_SPACE: begin
                if (tick && u == 3'd2) begin
                    complete   = 1'b1;
                    lv_n       = 1'b1;
                    acc_bits_n = '0;
                    acc_len_n  = '0;
                    ovf_n      = 1'b0;
                    armed_n    = 1'b1;
                    state_n    = rise ? S_MARK : S_IDLE;
                end else if (rise) begin
                    state_n = S_MARK;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Overflowed letters always report the unrecognised code.
    assign code_n = ovf ? 5'd31 : lookup(acc_len, acc_bits);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_d           <= 1'b0;
            p               <= '0;
            u               <= '0;
            acc_bits        <= '0;
            acc_len         <= '0;
            ovf             <= 1'b0;
            armed           <= 1'b0;
            rx.letter_valid <= 1'b0;
            rx.word_space   <= 1'b0;
            rx.letter_code  <= '0;
            rx.sym_bits     <= '0;
            rx.sym_len      <= '0;
            rx.sym_err      <= 1'b0;
        end else begin
            key_d    <= key_s;
            acc_bits <= acc_bits_n;
            acc_len  <= acc_len_n;
            ovf      <= ovf_n;
            armed    <= armed_n;
            p        <= (edge_s || tick) ? '0 : p + 1'b1;
            if (edge_s)                u <= '0;
            else if (complete)         u <= 3'd3;
            else if (tick && u != 3'd7) u <= u + 3'd1;
            rx.letter_valid <= lv_n;
            rx.word_space   <= ws_n;
            if (lv_n) begin
                rx.letter_code <= code_n;
                rx.sym_bits    <= acc_bits;
                rx.sym_len     <= acc_len;
                rx.sym_err     <= (code_n == 5'd31);
            end
        end
    end
endmodule
